// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the pipeline sequencing logic.
//   pipe_state_e : sequencing FSM states (RUN, FLUSH)
//   REG_ADDR_W   : register address width
//   NUM_REGS     : architectural register count
//   reg_onehot() : one-hot mask for a register address
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one busy bit per architectural register, tracking
// in-flight destination writes.
//   clk_i, rst_ni         : clock, async active-low reset
//   set_en_i, set_addr_i  : mark a register busy (issued writer)
//   clr_en_i, clr_addr_i  : retire a register write (writeback)
//   rs1/rs2/rd_addr_i     : lookup addresses
//   rs1/rs2/rd_busy_o     : lookup results against the effective view
//   busy_o                : registered busy vector
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  rd_busy_o,
  output logic [NUM_REGS-1:0]   busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] eff;

  // The register file is write-through, so a write retiring this cycle is
  // already visible to decode: lookups use the view with that bit cleared.
  always_comb begin
    eff = busy_q;
    if (clr_en_i) begin
      eff = eff & ~reg_onehot(clr_addr_i);
    end
    // Set is applied after clear so a same-register collision leaves it busy.
    busy_d = eff;
    if (set_en_i) begin
      busy_d = busy_d | reg_onehot(set_addr_i);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = eff[rs1_addr_i];
  assign rs2_busy_o = eff[rs2_addr_i];
  assign rd_busy_o  = eff[rd_addr_i];
  assign busy_o     = busy_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: decode-stage sequencing. Stalls the decode instruction on
// RAW/WAW hazards against the register scoreboard, issues it when clear, and
// squashes fetch/decode for FLUSH_CYCLES cycles after a redirect.
//   clk_i, rst_ni              : clock, async active-low reset
//   id_*_i                     : decode instruction operands and flags
//   wb_valid_i, wb_rd_i        : writeback retirement
//   redirect_i                 : taken branch / jump resolved in execute
//   id_issue_o, id_stall_o     : decode advance / hold
//   if_flush_o, id_flush_o     : squash fetch / decode
//   busy_o                     : scoreboard contents
//   stall_cnt_o                : hazard-stall cycle count (wraps)
//   dbg_state_o                : current FSM state
// Handshake: decode presents id_valid_i; in the same cycle either
// id_issue_o (instruction consumed) or id_stall_o (hold it) is asserted, or
// neither while flushing. All outputs are 0 while rst_ni is low.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_rd_we_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  redirect_i,
  output logic                  id_issue_o,
  output logic                  id_stall_o,
  output logic                  if_flush_o,
  output logic                  id_flush_o,
  output logic [NUM_REGS-1:0]   busy_o,
  output logic [31:0]           stall_cnt_o,
  output pipe_state_e           dbg_state_o
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  pipe_state_e   state_q, state_d;
  logic [3:0]    flush_cnt_q, flush_cnt_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic          rs1_busy, rs2_busy, rd_busy;
  logic          hazard;
  logic          issue_raw, stall_raw, flush_raw;
  logic          sb_set_en;
  logic [NUM_REGS-1:0] busy_raw;

  // x0 never reads as busy, so x0 operands cannot create a hazard.
  assign hazard = id_valid_i & ((id_rs1_used_i & rs1_busy) |
                                (id_rs2_used_i & rs2_busy) |
                                (id_rd_we_i    & rd_busy));

  assign sb_set_en = issue_raw & id_rd_we_i & (id_rd_i != '0);

  reg_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_en_i   (sb_set_en),
    .set_addr_i (id_rd_i),
    .clr_en_i   (wb_valid_i),
    .clr_addr_i (wb_rd_i),
    .rs1_addr_i (id_rs1_i),
    .rs2_addr_i (id_rs2_i),
    .rd_addr_i  (id_rd_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_busy_o  (rd_busy),
    .busy_o     (busy_raw)
  );

  // FSM next-state and per-cycle decisions.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    issue_raw   = 1'b0;
    stall_raw   = 1'b0;
    flush_raw   = redirect_i;
    case (state_q)
      RUN: begin
        issue_raw = id_valid_i & ~hazard & ~redirect_i;
        stall_raw = id_valid_i &  hazard & ~redirect_i;
        if (redirect_i) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_RELOAD;
        end
      end
      FLUSH: begin
        flush_raw = 1'b1;
        // A new redirect restarts the flush window from scratch.
        if (redirect_i) begin
          flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_raw) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      flush_cnt_q <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational outputs depend on live inputs, so they are gated by reset
  // explicitly rather than relying on the cleared registers.
  assign id_issue_o  = rst_ni & issue_raw;
  assign id_stall_o  = rst_ni & stall_raw;
  assign if_flush_o  = rst_ni & flush_raw;
  assign id_flush_o  = rst_ni & flush_raw;
  assign busy_o      = rst_ni ? busy_raw    : '0;
  assign stall_cnt_o = rst_ni ? stall_cnt_q : 32'd0;
  assign dbg_state_o = rst_ni ? state_q     : RUN;

endmodule
